// File: rtl/bus_timer_port.sv
// bus_timer_port: 6502 bus responder with a 16-bit down-counting interval timer (level irq) and an 8-bit parallel port.
// Latency: reads are combinational while selected; writes, timer ticks and irq update on the rising clk edge.
// Backpressure: none; the CPU bus has no wait states, so every access completes in the cycle it is presented.
// Ports: clk / clr (asynchronous, active-high), addr / rw / dataio CPU bus, irq level interrupt to the CPU,
//        pa_in port pins, pa_out port output values, pa_oe per-bit output enables (DDRA).
module bus_timer_port #(
    parameter logic [15:0] BASE = 16'hD000,
    parameter int unsigned DIV  = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] addr,
    input  logic        rw,
    inout  wire  [7:0]  dataio,
    output logic        irq,
    input  logic [7:0]  pa_in,
    output logic [7:0]  pa_out,
    output logic [7:0]  pa_oe
);
    localparam int            PW    = $clog2(DIV + 1);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ora_q, ddra_q, tll_q, tlh_q, snap_q, rdata, wdata;
    logic [15:0]   cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cont_q, ie_q, ie_d, t_q, t_d, irq_q;
    logic          sel, wr, rd, tick, uflow, reload, stop_wr;
    logic          wr_ora, wr_ddra, wr_tll, wr_tlh, wr_ctrl, wr_ifr, rd_cntl;
    logic [2:0]    off;

    assign sel     = (addr[15:3] == BASE[15:3]);
    assign off     = addr[2:0];
    assign wr      = sel & ~rw;
    assign rd      = sel & rw;
    assign wdata   = dataio;
    assign wr_ora  = wr && (off == 3'd0);
    assign wr_ddra = wr && (off == 3'd1);
    assign wr_tll  = wr && (off == 3'd2);
    assign wr_tlh  = wr && (off == 3'd3);
    assign wr_ctrl = wr && (off == 3'd6);
    assign wr_ifr  = wr && (off == 3'd7);
    assign rd_cntl = rd && (off == 3'd4);
    assign stop_wr = wr_ctrl & ~wdata[0];

    // Next-state logic. Later assignments override earlier ones, which encodes
    // the same-edge priorities: TLH write over everything, CTRL over the
    // timer's own run decision, and an underflow set of t over any clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        t_d     = t_q;
        ie_d    = ie_q;
        tick    = (state_q == COUNT) && (presc_q == PLAST);
        uflow   = tick && (cnt_q == 16'h0000);
        // A stop written on the underflow edge suppresses the auto-reload.
        reload  = uflow && cont_q && !stop_wr;

        if (state_q == COUNT) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        if (tick && (cnt_q != 16'h0000)) begin
            cnt_d = cnt_q - 16'd1;
        end else if (reload) begin
            cnt_d = {tlh_q, tll_q};
        end
        if (uflow && !cont_q) begin
            state_d = IDLE;
        end
        if (wr_ctrl) begin
            state_d = wdata[0] ? COUNT : IDLE;
            ie_d    = wdata[2];
        end
        if (uflow) begin
            t_d = 1'b1;
        end else if (rd_cntl || (wr_ifr && wdata[0])) begin
            t_d = 1'b0;
        end
        if (wr_tlh) begin
            cnt_d   = {wdata, tll_q};
            presc_d = '0;
            state_d = COUNT;
            t_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ora_q   <= 8'h00;
            ddra_q  <= 8'h00;
            tll_q   <= 8'hFF;
            tlh_q   <= 8'hFF;
            snap_q  <= 8'h00;
            cnt_q   <= 16'hFFFF;
            presc_q <= '0;
            cont_q  <= 1'b0;
            ie_q    <= 1'b0;
            t_q     <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            t_q     <= t_d;
            ie_q    <= ie_d;
            // Registered from the next-state values so irq is a single flop output.
            irq_q   <= t_d & ie_d;
            if (wr_ora)  ora_q  <= wdata;
            if (wr_ddra) ddra_q <= wdata;
            if (wr_tll)  tll_q  <= wdata;
            if (wr_tlh)  tlh_q  <= wdata;
            if (wr_ctrl) cont_q <= wdata[1];
            // High byte frozen alongside the CNTL read so CNTL/CNTH form one sample.
            if (rd_cntl) snap_q <= cnt_q[15:8];
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (off)
            3'd0: rdata = (ora_q & ddra_q) | (pa_in & ~ddra_q);
            3'd1: rdata = ddra_q;
            3'd2: rdata = tll_q;
            3'd3: rdata = tlh_q;
            3'd4: rdata = cnt_q[7:0];
            3'd5: rdata = snap_q;
            3'd6: rdata = {5'b00000, ie_q, cont_q, state_q == COUNT};
            3'd7: rdata = {t_q & ie_q, 6'b000000, t_q};
            default: rdata = 8'h00;
        endcase
    end

    assign dataio = rd ? rdata : 8'hzz;
    assign irq    = irq_q;
    assign pa_out = ora_q;
    assign pa_oe  = ddra_q;

endmodule

// File: tb/tb_bus_timer_port.sv
// tb_bus_timer_port: table vectors, hand sequences and random bus traffic against a behavioural model.
// Latency: one bus access per clock; reads sampled 1 time unit after the falling edge, state 1 unit after the rising edge.
// Backpressure: none; the bench drives dataio itself whenever the block must not, so a stray drive corrupts the value seen.
module tb_bus_timer_port;
    localparam logic [15:0] BASE = 16'hD000;
    localparam int unsigned DIV  = 1;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] addr;
    logic        rw;
    wire  [7:0]  dataio;
    logic        irq;
    logic [7:0]  pa_in, pa_out, pa_oe;
    logic        tb_en;
    logic [7:0]  tb_dat;
    logic [7:0]  cur_pin;

    assign dataio = tb_en ? tb_dat : 8'hzz;
    always #5 clk = ~clk;

    bus_timer_port #(.BASE(BASE), .DIV(DIV)) dut (
        .clk(clk), .clr(clr), .addr(addr), .rw(rw), .dataio(dataio),
        .irq(irq), .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h, expected %h", phase, name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_ora, m_ddra, m_tll, m_tlh, m_snap;
    int         m_cnt, m_pre;
    bit         m_run, m_cont, m_ie, m_t;

    task automatic m_reset();
        m_ora = 8'h00; m_ddra = 8'h00; m_tll = 8'hFF; m_tlh = 8'hFF; m_snap = 8'h00;
        m_cnt = 65535; m_pre = 0;
        m_run = 0; m_cont = 0; m_ie = 0; m_t = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] o);
        logic [15:0] c;
        c = 16'(m_cnt);
        case (o)
            3'd0: return (m_ora & m_ddra) | (pa_in & ~m_ddra);
            3'd1: return m_ddra;
            3'd2: return m_tll;
            3'd3: return m_tlh;
            3'd4: return c[7:0];
            3'd5: return m_snap;
            3'd6: return {5'b0, m_ie, m_cont, m_run};
            default: return {m_t & m_ie, 6'b0, m_t};
        endcase
    endfunction

    // Apply one clock edge: the timer acts first, then bus effects in rising priority.
    task automatic m_edge(input bit sel, input bit r, input logic [2:0] o, input logic [7:0] wd);
        logic [15:0] cnt0;
        bit          uf;
        bit          cont0;
        cnt0  = 16'(m_cnt);
        uf    = 0;
        cont0 = m_cont;
        if (m_run) begin
            if (m_pre == int'(DIV) - 1) begin
                m_pre = 0;
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    uf  = 1;
                    m_t = 1;
                    if (m_cont) m_cnt = {m_tlh, m_tll};
                    else        m_run = 0;
                end
            end else m_pre = m_pre + 1;
        end
        if (sel && r && o == 3'd4) begin
            m_snap = cnt0[15:8];
            if (!uf) m_t = 0;
        end
        if (sel && !r) begin
            case (o)
                3'd0: m_ora  = wd;
                3'd1: m_ddra = wd;
                3'd2: m_tll  = wd;
                3'd3: begin
                    m_tlh = wd; m_cnt = {wd, m_tll}; m_pre = 0; m_run = 1; m_t = 0;
                end
                3'd6: begin
                    m_run = wd[0]; m_cont = wd[1]; m_ie = wd[2];
                    if (uf && cont0 && !wd[0]) m_cnt = 0;
                end
                3'd7: if (wd[0] && !uf) m_t = 0;
                default: ;
            endcase
        end
    endtask

    // ---------------- bus access helpers ----------------
    task automatic cyc(input logic [15:0] a, input logic r, input logic [7:0] wd, output logic [7:0] rd);
        bit sel;
        sel = (a[15:3] == BASE[15:3]);
        @(negedge clk);
        addr   = a;
        rw     = r;
        pa_in  = cur_pin;
        tb_en  = !(sel && r);
        tb_dat = r ? 8'h00 : wd;
        #1;
        rd = dataio;
        if (sel && r) check("read", dataio, m_read(a[2:0]));
        else          check("bus_idle", dataio, tb_dat);
        @(posedge clk);
        m_edge(sel, r, a[2:0], wd);
        #1;
        check("irq", irq, m_t & m_ie);
        check("pa_out", pa_out, m_ora);
        check("pa_oe", pa_oe, m_ddra);
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] wd);
        logic [7:0] d;
        cyc(BASE + 16'(o), 1'b0, wd, d);
    endtask

    task automatic rdv(input logic [2:0] o, input logic [7:0] exp);
        logic [7:0] d;
        cyc(BASE + 16'(o), 1'b1, 8'h00, d);
        check($sformatf("rd_off%0d", o), d, exp);
    endtask

    task automatic idle();
        logic [7:0] d;
        cyc(16'h0000, 1'b1, 8'h00, d);
    endtask

    typedef struct {
        logic [2:0] off;
        logic       rw;
        logic [7:0] wd;
        logic [7:0] pin;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic run_vecs(input int lo, input int hi);
        logic [7:0] d;
        for (int i = lo; i <= hi; i++) begin
            cur_pin = vecs[i].pin;
            cyc(BASE + 16'(vecs[i].off), vecs[i].rw, vecs[i].wd, d);
            if (vecs[i].rw) check($sformatf("vec%0d", i), d, vecs[i].exp);
        end
    endtask

    logic [1:9] cont_irq = 9'b001001001;
    logic [1:9] cont_w1c = 9'b000100101;

    initial begin
        // rows 0-3: reset values; rows 4-7: parallel port
        vecs.push_back('{3'd2, 1'b1, 8'h00, 8'hFF, 8'hFF});
        vecs.push_back('{3'd3, 1'b1, 8'h00, 8'hFF, 8'hFF});
        vecs.push_back('{3'd6, 1'b1, 8'h00, 8'hFF, 8'h00});
        vecs.push_back('{3'd7, 1'b1, 8'h00, 8'hFF, 8'h00});
        vecs.push_back('{3'd1, 1'b0, 8'hF0, 8'h3C, 8'h00});
        vecs.push_back('{3'd0, 1'b0, 8'hA5, 8'h3C, 8'h00});
        vecs.push_back('{3'd0, 1'b1, 8'h00, 8'h3C, 8'hAC});
        vecs.push_back('{3'd1, 1'b1, 8'h00, 8'h3C, 8'hF0});

        clr = 1'b1; addr = 16'h0000; rw = 1'b1; tb_en = 1'b1; tb_dat = 8'h00;
        cur_pin = 8'hFF; pa_in = 8'hFF;
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_irq", irq, 1'b0);
        check("rst_pa_oe", pa_oe, 8'h00);
        check("rst_pa_out", pa_out, 8'h00);
        clr = 1'b0;

        phase = "reset"; run_vecs(0, 3);
        idle();
        phase = "port";  run_vecs(4, 7);
        check("port_pa_out", pa_out, 8'hA5);
        check("port_pa_oe", pa_oe, 8'hF0);

        phase = "oneshot";
        wr(3'd2, 8'h03); wr(3'd6, 8'h04); wr(3'd3, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            idle();
            check($sformatf("irq_e%0d", k), irq, k == 4);
        end
        rdv(3'd6, 8'h04);
        rdv(3'd4, 8'h00);
        check("irq_after_cntl", irq, 1'b0);
        rdv(3'd5, 8'h00);

        phase = "cont";
        wr(3'd7, 8'h01); wr(3'd6, 8'h06); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            if (cont_w1c[k]) wr(3'd7, 8'h01);
            else             idle();
            check($sformatf("irq_e%0d", k), irq, cont_irq[k]);
        end
        rdv(3'd7, 8'h81);
        wr(3'd6, 8'h00); wr(3'd7, 8'h01);

        phase = "atomic";
        wr(3'd2, 8'h00); wr(3'd3, 8'h01);
        rdv(3'd4, 8'h00); rdv(3'd5, 8'h01);
        rdv(3'd4, 8'hFE); rdv(3'd5, 8'h00);
        wr(3'd6, 8'h00);

        phase = "decode";
        begin
            logic [7:0] d;
            cyc(BASE - 16'd1, 1'b0, 8'h01, d);
            cyc(BASE - 16'd2, 1'b0, 8'h07, d);
            cyc(BASE + 16'd8, 1'b0, 8'h00, d);
            cyc(BASE + 16'd9, 1'b0, 8'h00, d);
            cyc(BASE - 16'd1, 1'b1, 8'h00, d);
            cyc(BASE + 16'd8, 1'b1, 8'h00, d);
        end
        check("dec_pa_out", pa_out, 8'hA5);
        check("dec_pa_oe", pa_oe, 8'hF0);
        rdv(3'd6, 8'h00);
        wr(3'd2, 8'h00); wr(3'd3, 8'h02); idle(); idle();
        wr(3'd2, 8'h10); wr(3'd3, 8'h00);
        rdv(3'd4, 8'h10); rdv(3'd5, 8'h00);
        wr(3'd6, 8'h00);

        phase = "rand";
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            logic        r;
            logic [7:0]  wd, d;
            if ($urandom_range(0, 99) < 85) a = BASE + 16'($urandom_range(0, 7));
            else                            a = 16'($urandom);
            r  = 1'($urandom);
            wd = 8'($urandom);
            if (a[15:3] == BASE[15:3] && a[2:0] == 3'd3) wd = 8'($urandom_range(0, 2));
            if (a[15:3] == BASE[15:3] && a[2:0] == 3'd2) wd = 8'($urandom_range(0, 15));
            cur_pin = 8'($urandom);
            cyc(a, r, wd, d);
        end

        phase = "midreset";
        cur_pin = 8'hFF;
        wr(3'd1, 8'hFF); wr(3'd0, 8'h5A);
        wr(3'd2, 8'h01); wr(3'd3, 8'h00); wr(3'd6, 8'h07);
        repeat (4) idle();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("async_irq", irq, 1'b0);
        check("async_pa_oe", pa_oe, 8'h00);
        check("async_pa_out", pa_out, 8'h00);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        run_vecs(0, 3);
        cur_pin = 8'hFF;
        repeat (4) idle();
        check("no_pending_irq", irq, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
